// File: rtl/mm_pkg.sv
// Shared types and default sizing for the 3x3 matrix-multiply sequencer slice.
package mm_pkg;

  localparam int unsigned MM_DATA_W = 4;
  localparam int unsigned MM_N      = 3;
  localparam int unsigned MM_ELEMS  = MM_N * MM_N;

  // Counter width that stays at least one bit for degenerate moduli.
  function automatic int unsigned cnt_width(input int unsigned modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

  localparam int unsigned MM_BEAT_W = cnt_width(MM_ELEMS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD_W,
    S_LOAD_X,
    S_WAIT,
    S_UNLOAD,
    S_ACC,
    S_DONE
  } mm_seq_state_t;

endpackage

// File: rtl/mm_sequencer_if.sv
// Element stream and bank/MAC control bundle; slave = sequencer side, master = host/bank side.
interface mm_sequencer_if
  import mm_pkg::*;
#(
  parameter int unsigned DATA_W = MM_DATA_W,
  parameter int unsigned N      = MM_N
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] mem_data;
  logic              load_w;
  logic              load_x;
  logic              mem_clear;
  logic [N-1:0]      unload;
  logic              acc_clr;
  logic              acc_en;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_data, load_w, load_x, mem_clear, unload, acc_clr, acc_en
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_data, load_w, load_x, mem_clear, unload, acc_clr, acc_en
  );

endinterface

// File: rtl/mm_beat_counter.sv
// Modulo-MOD up counter with enable, synchronous clear and a terminal-count flag.
module mm_beat_counter
  import mm_pkg::*;
#(
  parameter int unsigned MOD = MM_ELEMS,
  parameter int unsigned W   = cnt_width(MOD)
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == W'(MOD - 1));

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/mm_sequencer.sv
// Job sequencer for the matrix-multiply datapath: loads W then X into the bank, then unloads N phases.
// Optional MM_SEQ_ABORT_EN adds an 'abort' input that returns any active job to IDLE.
module mm_sequencer
  import mm_pkg::*;
#(
  parameter int unsigned DATA_W = MM_DATA_W,
  parameter int unsigned N      = MM_N
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         go,
`ifdef MM_SEQ_ABORT_EN
  input  logic         abort,
`endif
  mm_sequencer_if.slave bus,
  output logic         busy,
  output logic         done
);

  localparam int unsigned ELEMS  = N * N;
  localparam int unsigned BEAT_W = cnt_width(ELEMS);
  localparam int unsigned PH_W   = cnt_width(N);

  mm_seq_state_t     state, state_nxt;
  logic [BEAT_W-1:0] beat_cnt;
  logic              beat_last;
  logic [PH_W-1:0]   ph;
  logic              ph_last;
  logic              kill;
  logic              beat;
  logic              in_ready;
  logic              mem_clear;
  logic              acc_clr;
  logic              acc_en;
  logic [N-1:0]      unload;
  logic              load_w_q;
  logic              load_x_q;
  logic [DATA_W-1:0] mem_data_q;

`ifdef MM_SEQ_ABORT_EN
  assign kill = abort && (state != S_IDLE);
`else
  assign kill = 1'b0;
`endif

  assign beat = bus.in_valid && in_ready;

  mm_beat_counter #(.MOD(ELEMS), .W(BEAT_W)) u_beat (
    .clk   (clk),
    .clear (clear || (state == S_IDLE)),
    .en    (beat),
    .count (beat_cnt),
    .last  (beat_last)
  );

  mm_beat_counter #(.MOD(N), .W(PH_W)) u_phase (
    .clk   (clk),
    .clear (clear || (state == S_IDLE)),
    .en    (state == S_ACC),
    .count (ph),
    .last  (ph_last)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (go) state_nxt = S_CLR;
      S_CLR:    state_nxt = S_LOAD_W;
      S_LOAD_W: if (beat && beat_last) state_nxt = S_LOAD_X;
      S_LOAD_X: if (beat && beat_last) state_nxt = S_WAIT;
      S_WAIT:   state_nxt = S_UNLOAD;
      S_UNLOAD: state_nxt = S_ACC;
      S_ACC:    state_nxt = ph_last ? S_DONE : S_UNLOAD;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  // An abort cycle suppresses every strobe so nothing leaks out while the job is torn down.
  always_comb begin
    in_ready  = 1'b0;
    mem_clear = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    unload    = '0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    if (!kill) begin
      case (state)
        S_CLR: begin
          mem_clear = 1'b1;
          acc_clr   = 1'b1;
        end
        S_LOAD_W, S_LOAD_X: in_ready = 1'b1;
        S_UNLOAD: unload[ph] = 1'b1;
        S_ACC: begin
          unload[ph] = 1'b1;
          acc_en     = 1'b1;
        end
        S_DONE:  done = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      load_w_q   <= 1'b0;
      load_x_q   <= 1'b0;
      mem_data_q <= '0;
    end else begin
      load_w_q <= beat && (state == S_LOAD_W);
      load_x_q <= beat && (state == S_LOAD_X);
      if (beat) mem_data_q <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_data  = mem_data_q;
  assign bus.load_w    = load_w_q;
  assign bus.load_x    = load_x_q;
  assign bus.mem_clear = mem_clear;
  assign bus.unload    = unload;
  assign bus.acc_clr   = acc_clr;
  assign bus.acc_en    = acc_en;

  // The beat counter wraps on the final X beat, so it must read zero once loading is over.
  assert property (@(posedge clk) disable iff (clear)
    (state inside {S_WAIT, S_UNLOAD, S_ACC, S_DONE}) |-> (beat_cnt == '0));

endmodule

// File: tb/tb_mm_sequencer.sv
// Directed self-checking bench for mm_sequencer (default N=3, DATA_W=4).
module tb_mm_sequencer;

  logic clk;
  logic clear;
  logic go;
  logic busy;
  logic done;
`ifdef MM_SEQ_ABORT_EN
  logic abort;
`endif

  int n_tests;
  int n_fail;

  logic [3:0] w_src [9];
  logic [3:0] x_src [9];

  mm_sequencer_if #(.DATA_W(4), .N(3)) bus ();

  mm_sequencer #(.DATA_W(4), .N(3)) dut (
    .clk   (clk),
    .clear (clear),
    .go    (go),
`ifdef MM_SEQ_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus.slave),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] sample_vec();
    return {busy, done, bus.in_ready, bus.load_w, bus.load_x, bus.mem_clear,
            bus.acc_clr, bus.acc_en, bus.unload};
  endfunction

  // Hand timeline of an unthrottled job with go sampled at cycle 0.
  function automatic logic [10:0] exp_plain(input int c);
    logic       busy_e, done_e, rdy_e, lw_e, lx_e, clr_e, acc_e;
    logic [2:0] unl_e;
    busy_e = (c >= 1) && (c <= 27);
    done_e = (c == 27);
    rdy_e  = (c >= 2) && (c <= 19);
    lw_e   = (c >= 3) && (c <= 11);
    lx_e   = (c >= 12) && (c <= 20);
    clr_e  = (c == 1);
    acc_e  = (c == 22) || (c == 24) || (c == 26);
    unl_e  = (c == 21 || c == 22) ? 3'b001 :
             (c == 23 || c == 24) ? 3'b010 :
             (c == 25 || c == 26) ? 3'b100 : 3'b000;
    return {busy_e, done_e, rdy_e, lw_e, lx_e, clr_e, clr_e, acc_e, unl_e};
  endfunction

  // mode 0: in_valid always high; 1: high on odd cycles; 2: 20-cycle stall after 8 W beats.
  task automatic run_job(input int mode, input bit full, input bit extra_go,
                         input int clear_at, input int abort_at, output int done_c);
    int          idx, stall_left, nw, nx, clr_c;
    bit          cleared, fin;
    logic [10:0] v;
    logic [3:0]  gw [9];
    logic [3:0]  gx [9];
    logic [35:0] gp, ep;
    idx = 0; stall_left = 20; nw = 0; nx = 0; clr_c = -1;
    cleared = 1'b0; fin = 1'b0; done_c = -1;
    for (int i = 0; i < 9; i++) begin
      gw[i] = '0;
      gx[i] = '0;
    end
    @(posedge clk); #1;
    for (int c = 0; c < 120; c++) begin
      go = (c == 0) || (extra_go && (c == 5 || c == 27));
      case (mode)
        1: bus.in_valid = ((c % 2) == 1);
        2: begin
          bus.in_valid = !(idx == 8 && stall_left > 0);
          if (idx == 8 && stall_left > 0) stall_left--;
        end
        default: bus.in_valid = 1'b1;
      endcase
      bus.in_data = (idx < 9) ? w_src[idx] : (idx < 18) ? x_src[idx - 9] : 4'h0;
      clear = (clear_at >= 0) && (idx == clear_at) && !cleared;
      if (clear) begin
        cleared = 1'b1;
        clr_c   = c;
      end
`ifdef MM_SEQ_ABORT_EN
      abort = (c == abort_at);
`endif
      @(negedge clk);
      v = sample_vec();
      if (full) check($sformatf("vec@%0d", c), 64'(v), 64'(exp_plain(c)));
      if (mode == 2 && c == 20)
        check("stall_hold", 64'({busy, bus.in_ready, bus.load_w, bus.load_x}), 64'(4'b1100));
      if (bus.load_w) begin
        if (nw < 9) gw[nw] = bus.mem_data;
        nw++;
      end
      if (bus.load_x) begin
        if (nx < 9) gx[nx] = bus.mem_data;
        nx++;
      end
      if (done && done_c < 0) done_c = c;
      if (bus.in_valid && bus.in_ready) idx++;
      if (cleared && c == clr_c + 1) begin
        check("clr_vec", 64'(v), 64'(0));
        check("clr_mdata", 64'(bus.mem_data), 64'(0));
        fin = 1'b1;
      end
      if (abort_at >= 0 && c == abort_at + 1) check("abort_vec", 64'(v), 64'(0));
      if (abort_at >= 0 && c == abort_at + 12) fin = 1'b1;
      if (fin || (done && abort_at < 0)) break;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!cleared && abort_at < 0) begin
      check("w_cnt", 64'(nw), 64'(9));
      check("x_cnt", 64'(nx), 64'(9));
      gp = '0; ep = '0;
      for (int i = 0; i < 9; i++) begin
        gp = {gp[31:0], gw[i]};
        ep = {ep[31:0], w_src[i]};
      end
      check("w_data", 64'(gp), 64'(ep));
      gp = '0; ep = '0;
      for (int i = 0; i < 9; i++) begin
        gp = {gp[31:0], gx[i]};
        ep = {ep[31:0], x_src[i]};
      end
      check("x_data", 64'(gp), 64'(ep));
    end
  endtask

  initial begin
    int d;
    n_tests = 0;
    n_fail  = 0;
    clear = 1'b1;
    go    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
`ifdef MM_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_vec", 64'(sample_vec()), 64'(0));
    check("reset_mdata", 64'(bus.mem_data), 64'(0));
    clear = 1'b0;

    for (int i = 0; i < 9; i++) begin
      w_src[i] = 4'(i + 1);
      x_src[i] = 4'(9 - i);
    end
    run_job(0, 1'b1, 1'b0, -1, -1, d);
    check("plain_done", 64'(d), 64'(27));

    for (int i = 0; i < 9; i++) begin
      w_src[i] = 4'(15 - i);
      x_src[i] = 4'(i + 5);
    end
    run_job(0, 1'b0, 1'b1, -1, -1, d);
    check("gox_done", 64'(d), 64'(27));
    run_job(0, 1'b1, 1'b0, -1, -1, d);
    check("go28_done", 64'(d), 64'(27));

    for (int i = 0; i < 9; i++) begin
      w_src[i] = 4'(i * 3);
      x_src[i] = 4'(i * 7);
    end
    run_job(1, 1'b0, 1'b0, -1, -1, d);
    check("throttle_done", 64'(d), 64'(45));

    run_job(2, 1'b0, 1'b0, -1, -1, d);
    check("stall_done", 64'(d), 64'(47));

    run_job(0, 1'b0, 1'b0, 13, -1, d);
    check("clr_nodone", 64'(d), 64'(-1));
    for (int i = 0; i < 9; i++) begin
      w_src[i] = 4'(i + 1);
      x_src[i] = 4'(9 - i);
    end
    run_job(0, 1'b1, 1'b0, -1, -1, d);
    check("post_clr_done", 64'(d), 64'(27));

`ifdef MM_SEQ_ABORT_EN
    run_job(0, 1'b0, 1'b0, -1, 23, d);
    check("abort_nodone", 64'(d), 64'(-1));
    run_job(0, 1'b0, 1'b0, -1, -1, d);
    check("post_abort_done", 64'(d), 64'(27));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
